saturation_ctrl: RTL and testbench

Hold-to-repeat sequencer between the button debouncers and the saturating register. Converts two debounced key levels into single-cycle increment/decrement strobes: one strobe on press, then auto-repeat after an initial hold delay. It locks out contradictory presses and suppresses strobes the register cannot honour at its limits. Sits in the top level where debounced pulses currently feed the saturation block directly; its strobes replace those pulses.

---
 rtl/saturation_pkg.sv | 20 ++
 rtl/saturation_ctrl_step_timer.sv | 28 ++
 rtl/saturation_ctrl.sv | 142 ++++++++++++++
 tb/tb_saturation_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/saturation_pkg.sv
// Shared constants for the hold-to-repeat sequencer: state encoding,
// default hold/repeat cycle counts and the timer width helper.
package saturation_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    localparam int DEFAULT_DELAY_CYC  = 25_000_000;
    localparam int DEFAULT_REPEAT_CYC = 5_000_000;

    // Width able to hold max(delay, repeat) - 1, the largest value ever loaded.
    function automatic int timer_width(input int delay_cyc, input int repeat_cyc);
        int m;
        m = (delay_cyc > repeat_cyc) ? delay_cyc : repeat_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/saturation_ctrl_step_timer.sv
// Loadable down-counter used to pace the initial hold delay and the repeat
// interval. Load wins over enable; the count parks at zero.
module step_timer #(
    parameter int TW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/saturation_ctrl.sv
// Hold-to-repeat sequencer: turns debounced up/down key levels into one-cycle
// inc/dec strobes (press, then auto-repeat), with lockout and limit suppression.
module saturation_ctrl
    import saturation_pkg::*;
#(
    parameter int width      = 2,
    parameter int DELAY_CYC  = DEFAULT_DELAY_CYC,
    parameter int REPEAT_CYC = DEFAULT_REPEAT_CYC
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_up_lvl,
    input  logic           i_dn_lvl,
    input  logic [width:0] i_value,
    output logic           o_inc_pulse,
    output logic           o_dec_pulse,
    output logic           o_busy,
    output logic           o_at_limit,
    output logic [1:0]     o_dbg_state
);

    localparam int            TW          = timer_width(DELAY_CYC, REPEAT_CYC);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(DELAY_CYC - 1);
    localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYC - 1);

    logic [1:0]    r_state;
    logic          r_dir;
    logic          r_up_prev;
    logic          r_dn_prev;
    logic          r_inc;
    logic          r_dec;
    logic          r_busy;
    logic          r_at_limit;

    logic [1:0]    w_state_nxt;
    logic          w_dir_nxt;
    logic          w_strobe;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_tmr_en;
    logic          w_tmr_zero;
    logic          w_up_rise;
    logic          w_dn_rise;
    logic          w_active;
    logic          w_other;
    logic          w_val_max;
    logic          w_val_min;

    assign w_up_rise = i_up_lvl & ~r_up_prev;
    assign w_dn_rise = i_dn_lvl & ~r_dn_prev;
    assign w_active  = r_dir ? i_dn_lvl : i_up_lvl;
    assign w_other   = r_dir ? i_up_lvl : i_dn_lvl;
    assign w_val_max = &i_value;
    assign w_val_min = ~|i_value;

    step_timer #(
        .TW(TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_strobe    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A rise with the other key down (incl. simultaneous rises) is contradictory.
                if ((w_up_rise || w_dn_rise) && i_up_lvl && i_dn_lvl) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_up_rise || w_dn_rise) begin
                    w_dir_nxt   = w_dn_rise;
                    w_strobe    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = DELAY_LOAD;
                    w_state_nxt = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // Release outranks a lockout, which outranks a timer expiry.
                if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_other) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_tmr_zero) begin
                    w_strobe    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = REPEAT_LOAD;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_LOCK: begin
                if (!i_up_lvl && !i_dn_lvl) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_dir      <= 1'b0;
            r_up_prev  <= 1'b1;
            r_dn_prev  <= 1'b1;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_busy     <= 1'b0;
            r_at_limit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_up_prev  <= i_up_lvl;
            r_dn_prev  <= i_dn_lvl;
            // Strobes at a limit are dropped but the sequence keeps its pace.
            r_inc      <= w_strobe & ~w_dir_nxt & ~w_val_max;
            r_dec      <= w_strobe &  w_dir_nxt & ~w_val_min;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_at_limit <= w_val_max | w_val_min;
        end
    end

    assign o_inc_pulse = r_inc;
    assign o_dec_pulse = r_dec;
    assign o_busy      = r_busy;
    assign o_at_limit  = r_at_limit;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_saturation_ctrl.sv
// Directed bench for saturation_ctrl with a time-based reference model and
// hand-computed checks of strobe timing, lockout, suppression and reset.
module tb_saturation_ctrl;

    localparam int D = 4;
    localparam int R = 2;

    logic       clk;
    logic       rst_n;
    logic       up_lvl;
    logic       dn_lvl;
    logic [2:0] value;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       busy;
    logic       at_limit;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit track    = 0;

    saturation_ctrl #(
        .width      (2),
        .DELAY_CYC  (D),
        .REPEAT_CYC (R)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_up_lvl    (up_lvl),
        .i_dn_lvl    (dn_lvl),
        .i_value     (value),
        .o_inc_pulse (inc_pulse),
        .o_dec_pulse (dec_pulse),
        .o_busy      (busy),
        .o_at_limit  (at_limit),
        .o_dbg_state (dbg_state)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: mode 0 idle, 1 holding, 2 locked; repeat timing from elapsed edges.
    bit model_valid = 0;
    int k = 0;
    int mode = 0;
    int t0 = 0;
    bit mdir = 0;
    bit up_p = 1;
    bit dn_p = 1;
    bit e_inc = 0, e_dec = 0, e_busy = 0, e_lim = 0;
    int e_state = 0;

    always @(posedge clk) begin
        bit ru, rd, fire, act, oth;
        int el;
        k++;
        model_valid = 1;
        fire = 0;
        if (!rst_n) begin
            mode = 0; mdir = 0; up_p = 1; dn_p = 1;
            e_inc = 0; e_dec = 0; e_busy = 0; e_lim = 0; e_state = 0;
        end else begin
            ru = up_lvl & !up_p;
            rd = dn_lvl & !dn_p;
            case (mode)
                0: if (ru || rd) begin
                    if (up_lvl && dn_lvl) mode = 2;
                    else begin mode = 1; mdir = rd; t0 = k; fire = 1; end
                end
                1: begin
                    act = mdir ? dn_lvl : up_lvl;
                    oth = mdir ? up_lvl : dn_lvl;
                    el = k - t0;
                    if (!act) mode = 0;
                    else if (oth) mode = 2;
                    else if (el == D || (el > D && (el - D) % R == 0)) fire = 1;
                end
                default: if (!up_lvl && !dn_lvl) mode = 0;
            endcase
            e_inc  = fire && !mdir && value != 3'd7;
            e_dec  = fire &&  mdir && value != 3'd0;
            e_busy = (mode != 0);
            e_lim  = (value == 3'd0) || (value == 3'd7);
            e_state = (mode == 0) ? 0 : (mode == 2) ? 3 : ((k - t0) < D) ? 1 : 2;
            up_p = up_lvl;
            dn_p = dn_lvl;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("inc_pulse", int'(inc_pulse), int'(e_inc));
            check("dec_pulse", int'(dec_pulse), int'(e_dec));
            check("busy", int'(busy), int'(e_busy));
            check("at_limit", int'(at_limit), int'(e_lim));
            check("state", int'(dbg_state), e_state);
            n_checks++;
            if (inc_pulse && dec_pulse) begin
                n_fail++;
                $display("FAIL exclusive: got inc=1 dec=1 required not both");
            end
            if (track) begin
                if (inc_pulse && value != 3'd7) value = value + 3'd1;
                if (dec_pulse && value != 3'd0) value = value - 3'd1;
            end
        end
    end

    int got_q[$];
    int exp_q[$];
    int cnt;

    initial begin
        rst_n = 0; up_lvl = 1; dn_lvl = 0; value = 3'd3;
        tick(3);
        check("reset_inc", int'(inc_pulse), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_at_limit", int'(at_limit), 0);
        rst_n = 1;
        // Key held through reset release: no strobe.
        cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(1); cnt += int'(inc_pulse); end
        check("held_through_reset_strobes", cnt, 0);
        up_lvl = 0; tick(2);
        up_lvl = 1; tick(1);
        check("first_press_inc", int'(inc_pulse), 1);
        tick(1);
        check("first_press_inc_one_cycle", int'(inc_pulse), 0);
        up_lvl = 0; tick(3);

        // Hold for 12 cycles with value tracking from 0.
        value = 3'd0; track = 1;
        up_lvl = 1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (inc_pulse) got_q.push_back(i);
        end
        up_lvl = 0;
        exp_q = '{1, 5, 7, 9, 11};
        check("repeat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("repeat_offset", got_q[i], exp_q[i]);
        tick(1);
        check("busy_after_release", int'(busy), 0);
        check("tracked_value", int'(value), 5);
        track = 0;
        tick(2);

        // Upper limit: no increments.
        value = 3'd7; tick(1);
        up_lvl = 1; cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            cnt += int'(inc_pulse);
            if (i == 2) begin
                check("limit_busy", int'(busy), 1);
                check("limit_at_limit", int'(at_limit), 1);
            end
        end
        check("limit_inc_count", cnt, 0);
        up_lvl = 0; tick(2);
        value = 3'd0; tick(1);
        dn_lvl = 1; cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(1); cnt += int'(dec_pulse); end
        check("limit_dec_count", cnt, 0);
        dn_lvl = 0; tick(2);

        // Simultaneous rise locks out.
        value = 3'd3;
        up_lvl = 1; dn_lvl = 1; tick(3);
        check("both_lock", int'(dbg_state), 3);
        up_lvl = 0; tick(2);
        check("lock_one_held", int'(dbg_state), 3);
        dn_lvl = 0; tick(1);
        check("lock_exit", int'(dbg_state), 0);
        dn_lvl = 1; tick(1);
        check("fresh_dn_dec", int'(dec_pulse), 1);
        dn_lvl = 0; tick(3);

        // Lockout from REPEAT.
        up_lvl = 1; tick(6);
        check("in_repeat", int'(dbg_state), 2);
        dn_lvl = 1; tick(1);
        check("repeat_to_lock", int'(dbg_state), 3);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(1); cnt += int'(inc_pulse) + int'(dec_pulse); end
        check("lock_strobes", cnt, 0);
        up_lvl = 0; tick(2);
        check("lock_dn_held", int'(dbg_state), 3);
        dn_lvl = 0; tick(2);

        // Reset pulse during DELAY, just before the first repeat strobe.
        up_lvl = 1; tick(4);
        rst_n = 0; tick(1);
        check("reset_mid_inc", int'(inc_pulse), 0);
        check("reset_mid_state", int'(dbg_state), 0);
        rst_n = 1; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(inc_pulse); end
        check("held_after_reset_strobes", cnt, 0);
        up_lvl = 0; tick(2);
        up_lvl = 1; tick(1);
        check("repress_inc", int'(inc_pulse), 1);
        up_lvl = 0; tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
